// File: rtl/palette_fx_ctrl.sv
// Palette effects controller: index-range rotation, fade-out/hold/fade-in
// sequencing and registered, attenuated 12-bit RGB output.
module palette_fx_ctrl #(
    parameter int unsigned CYCLE_LO         = 9,
    parameter int unsigned CYCLE_HI         = 11,
    parameter int unsigned CYCLE_PERIOD     = 8,
    parameter int unsigned FADE_STEP_FRAMES = 2,
    parameter int unsigned HOLD_FRAMES      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       fade_req,
    input  logic [3:0] pixel_index,
    output logic [3:0] rom_index,
    input  logic [3:0] rom_red,
    input  logic [3:0] rom_green,
    input  logic [3:0] rom_blue,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [3:0] fade_level,
    output logic       fade_busy
);

    localparam logic [4:0]  LO5       = 5'(CYCLE_LO);
    localparam logic [4:0]  HI5       = 5'(CYCLE_HI);
    localparam logic [4:0]  N5        = 5'(CYCLE_HI - CYCLE_LO + 1);
    localparam logic [15:0] CYC_LAST  = 16'(CYCLE_PERIOD - 1);
    localparam logic [15:0] STEP_LAST = 16'(FADE_STEP_FRAMES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FADE_OUT,
        ST_HOLD,
        ST_FADE_IN
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [15:0] cyc_cnt_q, cyc_cnt_d;
    logic [15:0] st_cnt_q, st_cnt_d;
    logic [3:0]  level_q, level_d;
    logic        busy_q, busy_d;
    logic [3:0]  red_q, red_d;
    logic [3:0]  green_q, green_d;
    logic [3:0]  blue_q, blue_d;

    logic [4:0]  pix5;
    logic [4:0]  offset;
    logic [4:0]  remapped;
    logic        in_range;

    function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : 4'd0;
    endfunction

    // Rotation runs regardless of the fade state.
    always_comb begin
        phase_d   = phase_q;
        cyc_cnt_d = cyc_cnt_q;
        if (frame_start) begin
            if (cyc_cnt_q == CYC_LAST) begin
                cyc_cnt_d = '0;
                phase_d   = ({1'b0, phase_q} == N5 - 5'd1) ? 4'd0 : phase_q + 4'd1;
            end else begin
                cyc_cnt_d = cyc_cnt_q + 16'd1;
            end
        end
    end

    // Offset is at most 2N-2, so a single conditional subtract wraps it.
    always_comb begin
        pix5     = {1'b0, pixel_index};
        offset   = pix5 - LO5 + {1'b0, phase_q};
        if (offset >= N5) begin
            offset = offset - N5;
        end
        remapped = LO5 + offset;
        in_range = (pix5 >= LO5) && (pix5 <= HI5);
        rom_index = in_range ? remapped[3:0] : pixel_index;
    end

    always_comb begin
        state_d  = state_q;
        st_cnt_d = st_cnt_q;
        level_d  = level_q;
        unique case (state_q)
            ST_RUN: begin
                level_d = 4'd0;
                if (fade_req) begin
                    state_d  = ST_FADE_OUT;
                    st_cnt_d = '0;
                end
            end
            ST_FADE_OUT: begin
                if (frame_start) begin
                    if (st_cnt_q == STEP_LAST) begin
                        st_cnt_d = '0;
                        level_d  = level_q + 4'd1;
                        if (level_q == 4'd14) begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        st_cnt_d = st_cnt_q + 16'd1;
                    end
                end
            end
            ST_HOLD: begin
                level_d = 4'd15;
                if (frame_start) begin
                    if (st_cnt_q == HOLD_LAST) begin
                        st_cnt_d = '0;
                        state_d  = ST_FADE_IN;
                    end else begin
                        st_cnt_d = st_cnt_q + 16'd1;
                    end
                end
            end
            ST_FADE_IN: begin
                if (frame_start) begin
                    if (st_cnt_q == STEP_LAST) begin
                        st_cnt_d = '0;
                        level_d  = level_q - 4'd1;
                        if (level_q == 4'd1) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        st_cnt_d = st_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d  = ST_RUN;
                st_cnt_d = '0;
                level_d  = 4'd0;
            end
        endcase
        busy_d = (state_d != ST_RUN);
    end

    always_comb begin
        red_d   = sat_sub(rom_red, level_q);
        green_d = sat_sub(rom_green, level_q);
        blue_d  = sat_sub(rom_blue, level_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            phase_q   <= '0;
            cyc_cnt_q <= '0;
            st_cnt_q  <= '0;
            level_q   <= '0;
            busy_q    <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cyc_cnt_q <= cyc_cnt_d;
            st_cnt_q  <= st_cnt_d;
            level_q   <= level_d;
            busy_q    <= busy_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign fade_level = level_q;
    assign fade_busy  = busy_q;

endmodule

// File: tb/tb_palette_fx_ctrl.sv
// Directed bench for palette_fx_ctrl with a behavioural palette ROM.
module tb_palette_fx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       fade_req;
    logic [3:0] pixel_index;
    logic [3:0] rom_index;
    logic [3:0] rom_red, rom_green, rom_blue;
    logic [3:0] red, green, blue;
    logic [3:0] fade_level;
    logic       fade_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    palette_fx_ctrl #(
        .CYCLE_LO(9),
        .CYCLE_HI(11),
        .CYCLE_PERIOD(8),
        .FADE_STEP_FRAMES(2),
        .HOLD_FRAMES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .fade_req(fade_req),
        .pixel_index(pixel_index),
        .rom_index(rom_index),
        .rom_red(rom_red),
        .rom_green(rom_green),
        .rom_blue(rom_blue),
        .red(red),
        .green(green),
        .blue(blue),
        .fade_level(fade_level),
        .fade_busy(fade_busy)
    );

    function automatic logic [11:0] rom_f(input logic [3:0] idx);
        case (idx)
            4'd0:    return 12'h19E;
            4'd2:    return 12'hEA0;
            4'd3:    return 12'h3C8;
            4'd9:    return 12'h2AE;
            4'd10:   return 12'h277;
            4'd11:   return 12'h555;
            default: return {idx, 4'hF - idx, 4'h3};
        endcase
    endfunction

    always_comb {rom_red, rom_green, rom_blue} = rom_f(rom_index);

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_start = 1'b0; fade_req = 1'b0; pixel_index = 4'd2;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({red, green, blue} !== 12'h000 || fade_level !== 4'd0 || fade_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: rgb=%h lvl=%0d busy=%b, want rgb=000 lvl=0 busy=0",
                     {red, green, blue}, fade_level, fade_busy);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (rom_index !== 4'd2) begin
            tests_failed++;
            $display("FAIL reset_rom_index: got %0d want 2", rom_index);
        end
        @(negedge clk);
        tests_run++;
        if ({red, green, blue} !== 12'hEA0 || fade_level !== 4'd0 || fade_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_pixel: rgb=%h lvl=%0d busy=%b, want EA0 0 0",
                     {red, green, blue}, fade_level, fade_busy);
        end
    endtask

    task automatic test_rotation();
        repeat (8) pulse_frame();
        pixel_index = 4'd9; #1;
        tests_run++;
        if (rom_index !== 4'd10) begin
            tests_failed++;
            $display("FAIL rot_idx9: got %0d want 10", rom_index);
        end
        @(negedge clk);
        tests_run++;
        if ({red, green, blue} !== 12'h277) begin
            tests_failed++;
            $display("FAIL rot_rgb9: got %h want 277", {red, green, blue});
        end
        pixel_index = 4'd11; #1;
        tests_run++;
        if (rom_index !== 4'd9) begin
            tests_failed++;
            $display("FAIL rot_idx11: got %0d want 9", rom_index);
        end
        @(negedge clk);
        tests_run++;
        if ({red, green, blue} !== 12'h2AE) begin
            tests_failed++;
            $display("FAIL rot_rgb11: got %h want 2AE", {red, green, blue});
        end
        pixel_index = 4'd3; #1;
        tests_run++;
        if (rom_index !== 4'd3) begin
            tests_failed++;
            $display("FAIL rot_out_of_range: got %0d want 3", rom_index);
        end
        @(negedge clk);
    endtask

    // 24 frames since reset = 3 rotation steps, i.e. phase 0 again.
    task automatic test_wrap();
        repeat (16) pulse_frame();
        pixel_index = 4'd11; #1;
        tests_run++;
        if (rom_index !== 4'd11) begin
            tests_failed++;
            $display("FAIL wrap_idx11: got %0d want 11", rom_index);
        end
        pixel_index = 4'd10; #1;
        tests_run++;
        if (rom_index !== 4'd10) begin
            tests_failed++;
            $display("FAIL wrap_idx10: got %0d want 10", rom_index);
        end
        @(negedge clk);
    endtask

    function automatic logic [3:0] exp_level(input int f);
        if (f <= 30) return 4'(f / 2);
        if (f <= 46) return 4'd15;
        return 4'(15 - (f - 46) / 2);
    endfunction

    task automatic test_fade_and_full_sequence();
        fade_req = 1'b1;
        @(negedge clk);
        fade_req = 1'b0;
        tests_run++;
        if (fade_busy !== 1'b1 || fade_level !== 4'd0) begin
            tests_failed++;
            $display("FAIL fade_entry: busy=%b lvl=%0d want 1 0", fade_busy, fade_level);
        end
        repeat (6) pulse_frame();
        tests_run++;
        if (fade_level !== 4'd3) begin
            tests_failed++;
            $display("FAIL fade_lvl3: got %0d want 3", fade_level);
        end
        pixel_index = 4'd2;
        @(negedge clk);
        tests_run++;
        if ({red, green, blue} !== 12'hB70) begin
            tests_failed++;
            $display("FAIL fade_rgb2: got %h want B70", {red, green, blue});
        end
        pixel_index = 4'd0;
        @(negedge clk);
        tests_run++;
        if ({red, green, blue} !== 12'h06B) begin
            tests_failed++;
            $display("FAIL fade_rgb0_sat: got %h want 06B", {red, green, blue});
        end
        for (int f = 7; f <= 76; f++) begin
            pulse_frame();
            tests_run++;
            if (fade_level !== exp_level(f) || fade_busy !== (f < 76)) begin
                tests_failed++;
                $display("FAIL seq_frame%0d: lvl=%0d busy=%b want lvl=%0d busy=%b",
                         f, fade_level, fade_busy, exp_level(f), (f < 76));
            end
            if (f == 38) begin
                fade_req = 1'b1;
                @(negedge clk);
                fade_req = 1'b0;
                @(negedge clk);
                tests_run++;
                if (fade_level !== 4'd15 || fade_busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL hold_ignores_req: lvl=%0d busy=%b want 15 1",
                             fade_level, fade_busy);
                end
            end
        end
        repeat (3) pulse_frame();
        tests_run++;
        if (fade_busy !== 1'b0 || fade_level !== 4'd0) begin
            tests_failed++;
            $display("FAIL no_queued_req: busy=%b lvl=%0d want 0 0", fade_busy, fade_level);
        end
    endtask

    task automatic test_reset_mid_fade();
        fade_req = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        fade_req = 1'b0; frame_start = 1'b0;
        tests_run++;
        if (fade_busy !== 1'b1 || fade_level !== 4'd0) begin
            tests_failed++;
            $display("FAIL coincident_entry: busy=%b lvl=%0d want 1 0", fade_busy, fade_level);
        end
        pulse_frame();
        tests_run++;
        if (fade_level !== 4'd0) begin
            tests_failed++;
            $display("FAIL coincident_not_counted: lvl=%0d want 0", fade_level);
        end
        for (int f = 2; f <= 62; f++) pulse_frame();
        tests_run++;
        if (fade_level !== 4'd7 || fade_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL fade_in_lvl7: lvl=%0d busy=%b want 7 1", fade_level, fade_busy);
        end
        pixel_index = 4'd2;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (fade_level !== 4'd0 || fade_busy !== 1'b0 || {red, green, blue} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_mid_fade: lvl=%0d busy=%b rgb=%h want 0 0 000",
                     fade_level, fade_busy, {red, green, blue});
        end
        reset = 1'b0;
        pixel_index = 4'd9; #1;
        tests_run++;
        if (rom_index !== 4'd9) begin
            tests_failed++;
            $display("FAIL reset_phase0: rom_index=%0d want 9", rom_index);
        end
        @(negedge clk);
        tests_run++;
        if ({red, green, blue} !== 12'h2AE) begin
            tests_failed++;
            $display("FAIL post_reset_rgb: got %h want 2AE", {red, green, blue});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_rotation();
        test_wrap();
        test_fade_and_full_sequence();
        test_reset_mid_fade();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/palette_fx_ctrl.md
# palette_fx_ctrl

Per-frame palette effects controller placed between the renderer's 4-bit colour index and the 16-entry palette ROM. It rotates a configurable contiguous index range for water and waterfall shimmer. It runs a fade-out / hold / fade-in sequence for zone transitions. It registers the faded 12-bit RGB that goes to the VGA output stage.

## Interface
- CYCLE_LO, 9: lowest palette index in the rotation range.
- CYCLE_HI, 11: highest palette index in the rotation range; CYCLE_LO ≤ CYCLE_HI ≤ 15.
- CYCLE_PERIOD, 8: frames per rotation step, ≥ 1.
- FADE_STEP_FRAMES, 2: frames per fade-level step, ≥ 1.
- HOLD_FRAMES, 16: frames held fully black, ≥ 1.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- fade_req  in  1  one-cycle pulse that starts a fade sequence.
- pixel_index  in  4  colour index requested by the renderer.
- rom_index  out  4  remapped index driven to the palette ROM (combinational).
- rom_red, rom_green, rom_blue  in  4 each  palette ROM data (combinational from rom_index).
- red, green, blue  out  4 each  registered, faded colour.
- fade_level  out  4  current fade attenuation, 0 to 15.
- fade_busy  out  1  high in any state other than RUN.

## Operation
- Rotation range: N = CYCLE_HI − CYCLE_LO + 1.
- phase register: 0 to N−1.
- cyc_cnt counter: counts frame_start pulses. When cyc_cnt = CYCLE_PERIOD−1 on a frame_start, cyc_cnt clears and phase = (phase+1) mod N. Otherwise cyc_cnt increments.
- Rotation runs in every state.
- Remap, in-range (CYCLE_LO ≤ pixel_index ≤ CYCLE_HI): rom_index = CYCLE_LO + ((pixel_index − CYCLE_LO + phase) mod N). Compute with 5-bit intermediates; the result wraps within the range.
- Remap, out-of-range: rom_index = pixel_index.
- Fade arithmetic: each channel output = rom_channel − fade_level, saturated at 0. All channels use the same fade_level.
- FSM states: RUN, FADE_OUT, HOLD, FADE_IN. A step counter st_cnt clears on every state entry.
- RUN:
  - fade_level = 0.
  - fade_req → FADE_OUT.
- FADE_OUT:
  - On a frame_start with st_cnt = FADE_STEP_FRAMES−1: fade_level increments and st_cnt clears. Otherwise a frame_start increments st_cnt.
  - When fade_level becomes 15 → HOLD.
- HOLD:
  - fade_level = 15.
  - After HOLD_FRAMES frame_starts → FADE_IN.
- FADE_IN:
  - Same stepping as FADE_OUT, but fade_level decrements.
  - When fade_level becomes 0 → RUN.
- fade_req is ignored whenever fade_busy = 1. Requests are not queued.

## Timing
- Reset values: red, green, blue = 0; fade_level = 0; fade_busy = 0; phase = 0; all counters = 0; state = RUN.
- Reset mid-sequence aborts the fade and returns to RUN on the next edge.
- Pixel latency is one cycle. red/green/blue at edge k+1 reflect pixel_index, phase and fade_level sampled at edge k.
- rom_index has zero latency from pixel_index and phase.
- A full sequence from fade_req takes:
  - 15·FADE_STEP_FRAMES frame_starts to reach level 15;
  - HOLD_FRAMES more in HOLD;
  - 15·FADE_STEP_FRAMES more to return to RUN.
- With defaults, that is 30 + 16 + 30 = 76 frame_starts.
- fade_req and frame_start in the same RUN cycle: the state becomes FADE_OUT at that edge. That frame_start does not count toward the first step.
- fade_level, phase and state change only on frame_start edges, apart from the RUN→FADE_OUT entry and reset. Colours are therefore stable within a visible frame.
- fade_busy is registered: it is high from the edge that enters FADE_OUT through the edge that re-enters RUN.

## Test plan
- Reset, then pixel_index = 2 → next cycle {red,green,blue} = {E,A,0}; fade_level = 0; fade_busy = 0; rom_index = 2.
- 8 frame_starts (phase 1) → pixel_index 9 gives rom_index 10 and output {2,7,7}; pixel_index 11 gives rom_index 9 and output {2,A,E}; pixel_index 3 is unchanged at rom_index 3.
- 24 frame_starts (phase back to 0) → pixel_index 11 gives rom_index 11, confirming wrap-around.
- fade_req, then 6 frame_starts → fade_level = 3; pixel_index 2 gives {B,7,0}; pixel_index 0 gives {0,6,B}, saturating red at 0.
- Full sequence: fade_req, then 76 frame_starts → fade_level goes 0→15, holds for 16 frames, then 15→0. fade_busy drops on the 76th. A second fade_req issued mid-HOLD has no effect.
- Reset asserted during FADE_IN at fade_level 7 → next cycle fade_level = 0, fade_busy = 0, phase = 0, outputs = 0.
